// File: rtl/vram_blit_ctrl_pkg.sv
// Shared types, widths and frame-compare helper for the VRAM blit scheduler.
package vram_blit_ctrl_pkg;

  localparam int FRAME_W_DEF = 32;
  localparam int PIX_W_DEF   = 24;
  localparam int LINE_W_DEF  = 16;
  localparam int STAT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ARM    = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4
  } blit_state_e;

  // True when frame a lies strictly after frame b, tolerant of counter wrap.
  function automatic logic frame_after(input logic [FRAME_W_DEF-1:0] a,
                                       input logic [FRAME_W_DEF-1:0] b);
    logic [FRAME_W_DEF-1:0] d;
    d = a - b;
    return (d != {FRAME_W_DEF{1'b0}}) && !d[FRAME_W_DEF-1];
  endfunction

endpackage

// File: rtl/vram_blit_ctrl_if.sv
// Command, pixel, vram and statistics signals between the blit scheduler and its neighbours.
interface vram_blit_ctrl_if #(
  parameter int FRAME_W = vram_blit_ctrl_pkg::FRAME_W_DEF,
  parameter int PIX_W   = vram_blit_ctrl_pkg::PIX_W_DEF,
  parameter int LINE_W  = vram_blit_ctrl_pkg::LINE_W_DEF
);
  import vram_blit_ctrl_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [FRAME_W-1:0] cmd_frame;
  logic [PIX_W-1:0]   cmd_pixels;
  logic [LINE_W-1:0]  cmd_line;
  logic               cmd_stop;
  logic               px_valid;
  logic               px_ready;
  logic [23:0]        px_rgb;
  logic               vram_ready;
  logic               vram_synced;
  logic [FRAME_W-1:0] vga_frame;
  logic [LINE_W-1:0]  vcount;
  logic               vram_req;
  logic [7:0]         r_vram_in;
  logic [7:0]         g_vram_in;
  logic [7:0]         b_vram_in;
  logic               vram_active;
  logic               vram_reset;
  logic               vga_frame_reset;
  logic               vga_wait_vblank;
  logic [STAT_W-1:0]  frames_done;
  logic [STAT_W-1:0]  frames_dropped;
  logic [STAT_W-1:0]  resyncs;

  modport master (
    output cmd_valid, cmd_frame, cmd_pixels, cmd_line, cmd_stop,
    output px_valid, px_rgb, vram_ready, vram_synced, vga_frame, vcount,
    input  cmd_ready, px_ready, vram_req, r_vram_in, g_vram_in, b_vram_in,
    input  vram_active, vram_reset, vga_frame_reset, vga_wait_vblank,
    input  frames_done, frames_dropped, resyncs
  );

  modport slave (
    input  cmd_valid, cmd_frame, cmd_pixels, cmd_line, cmd_stop,
    input  px_valid, px_rgb, vram_ready, vram_synced, vga_frame, vcount,
    output cmd_ready, px_ready, vram_req, r_vram_in, g_vram_in, b_vram_in,
    output vram_active, vram_reset, vga_frame_reset, vga_wait_vblank,
    output frames_done, frames_dropped, resyncs
  );

endinterface

// File: rtl/vram_blit_ctrl_stat_cnt.sv
// Saturating event counter used for the blit statistics.
module blit_stat_cnt
  import vram_blit_ctrl_pkg::*;
(
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              i_inc,
  output logic [STAT_W-1:0] o_cnt
);

  logic [STAT_W-1:0] r_cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {STAT_W{1'b1}})) begin
      r_cnt <= r_cnt + STAT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vram_blit_ctrl.sv
// VRAM blit scheduler: arms one blit per frame against the raster, gates pixels
// into the vram write port, and recovers from vram read underruns.
module vram_blit_ctrl
  import vram_blit_ctrl_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int LINE_W  = LINE_W_DEF
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  vram_blit_ctrl_if.slave bus
);

  blit_state_e        r_state;
  blit_state_e        w_state_nxt;
  logic [FRAME_W-1:0] r_cur_frame;
  logic [LINE_W-1:0]  r_cur_line;
  logic [PIX_W-1:0]   r_remaining;
  logic [PIX_W-1:0]   w_remaining_nxt;
  logic               r_run;
  logic               r_vram_active, w_vram_active_nxt;
  logic               r_vram_reset, w_vram_reset_nxt;
  logic               r_frame_reset, w_frame_reset_nxt;
  logic               r_wait_vblank, w_wait_vblank_nxt;
  logic               r_vram_req;
  logic [23:0]        r_rgb;
  logic               w_load, w_write, w_cmd_ready, w_px_ready;
  logic               w_inc_done, w_inc_drop, w_inc_resync;
  logic               w_stop, w_underrun, w_arm_go, w_rem_zero;
  logic [STAT_W-1:0]  w_frames_done, w_frames_dropped, w_resyncs;

  // Stop only acts while there is something to tear down, so a held level yields one reset pulse.
  assign w_stop     = bus.cmd_stop && ((r_state != ST_IDLE) || r_vram_active);
  assign w_underrun = !bus.vram_synced && r_vram_active &&
                      ((r_state == ST_ARM) || (r_state == ST_STREAM));
  assign w_rem_zero = (r_remaining == '0);
  assign w_arm_go   = (r_cur_line == '0) ||
                      ((bus.vga_frame == (r_cur_frame - FRAME_W'(1))) && (bus.vcount >= r_cur_line)) ||
                      !frame_after(r_cur_frame, bus.vga_frame);

  always_comb begin
    w_state_nxt       = r_state;
    w_remaining_nxt   = r_remaining;
    w_vram_active_nxt = r_vram_active;
    w_vram_reset_nxt  = 1'b0;
    w_frame_reset_nxt = 1'b0;
    w_wait_vblank_nxt = 1'b0;
    w_load            = 1'b0;
    w_write           = 1'b0;
    w_cmd_ready       = 1'b0;
    w_px_ready        = 1'b0;
    w_inc_done        = 1'b0;
    w_inc_drop        = 1'b0;
    w_inc_resync      = 1'b0;
    if (w_stop) begin
      w_state_nxt       = ST_IDLE;
      w_vram_active_nxt = 1'b0;
      w_vram_reset_nxt  = 1'b1;
    end else if (w_underrun) begin
      // Underrun wins over the pixel handshake: px_ready stays low this cycle.
      w_state_nxt       = ST_FLUSH;
      w_vram_reset_nxt  = 1'b1;
      w_wait_vblank_nxt = 1'b1;
      w_inc_resync      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cmd_ready = r_run && bus.vram_synced && !bus.cmd_stop;
          if (w_cmd_ready && bus.cmd_valid) begin
            w_load          = 1'b1;
            w_remaining_nxt = bus.cmd_pixels;
            if (!r_vram_active) begin
              w_state_nxt = ST_START;
            end else if (!frame_after(bus.cmd_frame, bus.vga_frame)) begin
              w_inc_drop  = 1'b1;
              w_state_nxt = ST_FLUSH;
            end else begin
              w_state_nxt = ST_ARM;
            end
          end else begin
            w_load = 1'b0;
          end
        end
        ST_START: begin
          w_vram_reset_nxt  = 1'b1;
          w_frame_reset_nxt = 1'b1;
          w_vram_active_nxt = 1'b1;
          w_state_nxt       = ST_ARM;
        end
        ST_ARM: begin
          if (w_arm_go) begin
            w_state_nxt = ST_STREAM;
          end else begin
            w_state_nxt = ST_ARM;
          end
        end
        ST_STREAM: begin
          if (w_rem_zero) begin
            w_inc_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_px_ready = bus.vram_ready;
            if (w_px_ready && bus.px_valid) begin
              w_write         = 1'b1;
              w_remaining_nxt = r_remaining - PIX_W'(1);
            end else begin
              w_write = 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (w_rem_zero) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_px_ready = 1'b1;
            if (bus.px_valid) begin
              w_remaining_nxt = r_remaining - PIX_W'(1);
            end else begin
              w_remaining_nxt = r_remaining;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_run keeps cmd_ready low until the first clock after reset release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_run         <= 1'b0;
      r_cur_frame   <= '0;
      r_cur_line    <= '0;
      r_remaining   <= '0;
      r_vram_active <= 1'b0;
      r_vram_reset  <= 1'b0;
      r_frame_reset <= 1'b0;
      r_wait_vblank <= 1'b0;
      r_vram_req    <= 1'b0;
      r_rgb         <= 24'h000000;
    end else begin
      r_run         <= 1'b1;
      r_remaining   <= w_remaining_nxt;
      r_vram_active <= w_vram_active_nxt;
      r_vram_reset  <= w_vram_reset_nxt;
      r_frame_reset <= w_frame_reset_nxt;
      r_wait_vblank <= w_wait_vblank_nxt;
      r_vram_req    <= w_write;
      if (w_load) begin
        r_cur_frame <= bus.cmd_frame;
        r_cur_line  <= bus.cmd_line;
      end
      if (w_write) begin
        r_rgb <= bus.px_rgb;
      end
    end
  end

  blit_stat_cnt u_cnt_done (
    .clk_sys (clk_sys),
    .rst_n   (reset_n),
    .i_inc   (w_inc_done),
    .o_cnt   (w_frames_done)
  );

  blit_stat_cnt u_cnt_drop (
    .clk_sys (clk_sys),
    .rst_n   (reset_n),
    .i_inc   (w_inc_drop),
    .o_cnt   (w_frames_dropped)
  );

  blit_stat_cnt u_cnt_resync (
    .clk_sys (clk_sys),
    .rst_n   (reset_n),
    .i_inc   (w_inc_resync),
    .o_cnt   (w_resyncs)
  );

  assign bus.cmd_ready       = w_cmd_ready;
  assign bus.px_ready        = w_px_ready;
  assign bus.vram_req        = r_vram_req;
  assign bus.r_vram_in       = r_rgb[23:16];
  assign bus.g_vram_in       = r_rgb[15:8];
  assign bus.b_vram_in       = r_rgb[7:0];
  assign bus.vram_active     = r_vram_active;
  assign bus.vram_reset      = r_vram_reset;
  assign bus.vga_frame_reset = r_frame_reset;
  assign bus.vga_wait_vblank = r_wait_vblank;
  assign bus.frames_done     = w_frames_done;
  assign bus.frames_dropped  = w_frames_dropped;
  assign bus.resyncs         = w_resyncs;

endmodule

// File: doc/vram_blit_ctrl.md
Name: vram_blit_ctrl

Overview:
- Scheduler between the frame/pixel ingest path and the vram-backed VGA timing block.
- Accepts one blit command per frame (target frame, pixel count, arm line).
- Gates the pixel stream into the block's vram write port at the right point in the raster.
- Owns vram_active, vram/frame resets and resync after a vram underrun; keeps frame statistics.

Parameters:
- FRAME_W, 32, width of frame numbers (matches vga_frame).
- PIX_W, 24, width of pixel counts (matches vram_pixels).
- LINE_W, 16, width of line numbers (matches vcount).

Ports:
- clk_sys  in  1  system clock; every flop on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  blit command valid.
- cmd_ready  out  1  blit command accepted when valid&ready.
- cmd_frame  in  FRAME_W  frame number the blit targets.
- cmd_pixels  in  PIX_W  pixel count of the blit.
- cmd_line  in  LINE_W  arm line; 0 means stream immediately.
- cmd_stop  in  1  level; leave vram mode.
- px_valid  in  1  source pixel valid.
- px_ready  out  1  source pixel accepted when valid&ready.
- px_rgb  in  24  pixel {r,g,b}.
- vram_ready  in  1  vram has room.
- vram_synced  in  1  low = vram read underrun.
- vga_frame  in  FRAME_W  frame counter from the timing block.
- vcount  in  LINE_W  current line.
- vram_req  out  1  one-cycle write strobe.
- r_vram_in, g_vram_in, b_vram_in  out  8 each  write data, valid with vram_req.
- vram_active  out  1  timing block displays from vram.
- vram_reset  out  1  one-cycle vram pointer reset.
- vga_frame_reset  out  1  one-cycle frame counter reset.
- vga_wait_vblank  out  1  one-cycle "restart reads at next vblank".
- frames_done, frames_dropped, resyncs  out  16 each  saturating statistics.

Behaviour:
- Reset (async): state IDLE; vram_active=0, all strobes 0, cmd_ready=0, px_ready=0, counters 0, rgb outputs 0.
- States: IDLE, START, ARM, STREAM, FLUSH.
- IDLE: cmd_ready=1 only when vram_synced=1 and cmd_stop=0.
- On accept, latch frame, pixels and line into cur_*.
- If vram_active=0: go to START.
- Else if $signed(cmd_frame - vga_frame) <= 0: the command is stale. Increment frames_dropped and go to FLUSH with cur_pixels as the sink count.
- Else: go to ARM.
- START: pulse vram_reset and vga_frame_reset for 1 cycle, set vram_active=1, then go to ARM.
- ARM: go to STREAM when either condition holds:
  - cur_line==0; or
  - (vga_frame == cur_frame-1 and vcount >= cur_line); or
  - $signed(vga_frame - cur_frame) >= 0.
- STREAM: px_ready = vram_ready & (remaining != 0).
- Each accepted pixel: the next cycle has vram_req=1 with registered rgb (1-cycle latency), and remaining decrements.
- vram_req is never high when the previous cycle's vram_ready was 0.
- When remaining reaches 0 (or cur_pixels==0 on entry): increment frames_done and return to IDLE.
- Underrun: vram_synced=0 while vram_active=1 in ARM or STREAM:
  - pulse vram_reset and vga_wait_vblank for 1 cycle;
  - increment resyncs;
  - go to FLUSH with the remaining count.
- Underrun has priority over the pixel handshake in the same cycle; that pixel is not written.
- FLUSH: px_ready=1, vram_req stays 0, sink the remaining pixels. At 0, go to IDLE.
- FLUSH ignores vram_synced.
- cmd_stop=1, any state except reset:
  - next cycle vram_active=0 and one vram_reset pulse;
  - the current command is abandoned without counting;
  - state returns to IDLE.
  - Pixels already in flight are left for the source to discard.
- Frame comparisons use wrap-safe signed FRAME_W differences.
- Statistics counters saturate at 16'hFFFF.
- Strobes are registered and last exactly 1 cycle. They never overlap in a way that produces vram_req in the same cycle as vram_reset.

Decomposition:
- Shared package holds:
  - the state enum;
  - FRAME_W, PIX_W, LINE_W defaults;
  - the stat-counter width;
  - a frame_after(a,b) wrap-safe compare function.
- One sub-module is natural: blit_stat_cnt, a 16-bit saturating counter with an increment strobe, instantiated three times.

Test Plan:
- First blit: vram_active=0, cmd {frame=5, pixels=4, line=0}, px always valid, vram_ready=1 → one vram_reset and one vga_frame_reset pulse, vram_active=1, exactly 4 vram_req with the pixel data in order, frames_done=1.
- Arming: active, vga_frame=9, cmd {frame=10, line=200, pixels=3}. vcount steps 198→200 → no px_ready before vcount=200; 3 writes afterwards.
- Stale: vga_frame=20, cmd frame=20, pixels=6 → frames_dropped=1, 6 pixels sunk, zero vram_req. Repeat with vga_frame=32'hFFFFFFFF and cmd frame=1 → not stale.
- Backpressure: vram_ready toggles every 2 cycles during a 10-pixel blit → exactly 10 vram_req, none in the cycle after vram_ready=0.
- Underrun: drop vram_synced after 3 of 8 pixels → vram_reset and vga_wait_vblank pulse once, resyncs=1, 5 pixels sunk, cmd_ready stays low until vram_synced=1.
- Stop/reset: cmd_stop mid-STREAM → vram_active=0 next cycle, 1 vram_reset pulse, IDLE. Assert reset_n=0 mid-STREAM → outputs 0 immediately, asynchronously.
